// File: rtl/vga_mapa_grade_if.sv
// Board renderer bus: pixel stream from the timing generator,
// game-side cell write port, cursor buttons and colour/cursor outputs.
interface vga_mapa_grade_if #(
  parameter int N_COLS = 8,
  parameter int N_ROWS = 8
);
  localparam int CW = $clog2(N_COLS);
  localparam int RW = $clog2(N_ROWS);

  logic          areaAtiva;
  logic [9:0]    linha;
  logic [9:0]    coluna;
  logic          btn_up;
  logic          btn_down;
  logic          btn_left;
  logic          btn_right;
  logic          wr_en;
  logic [CW-1:0] wr_col;
  logic [RW-1:0] wr_row;
  logic [1:0]    wr_state;
  logic          clr;
  logic [CW-1:0] cursor_col;
  logic [RW-1:0] cursor_row;
  logic [1:0]    cursor_state;
  logic          rgb_r;
  logic          rgb_g;
  logic          rgb_b;

  modport master (
    output areaAtiva, linha, coluna,
    output btn_up, btn_down, btn_left, btn_right,
    output wr_en, wr_col, wr_row, wr_state, clr,
    input  cursor_col, cursor_row, cursor_state,
    input  rgb_r, rgb_g, rgb_b
  );

  modport slave (
    input  areaAtiva, linha, coluna,
    input  btn_up, btn_down, btn_left, btn_right,
    input  wr_en, wr_col, wr_row, wr_state, clr,
    output cursor_col, cursor_row, cursor_state,
    output rgb_r, rgb_g, rgb_b
  );
endinterface

// File: rtl/vga_mapa_grade.sv
// Battleship board renderer: gridlines, per-cell state colours and
// a blinking cursor, three register stages from pixel to rgb.
module vga_mapa_grade #(
  parameter int N_COLS       = 8,
  parameter int N_ROWS       = 8,
  parameter int X0           = 20,
  parameter int Y0           = 40,
  parameter int CELL_W       = 75,
  parameter int CELL_H       = 50,
  parameter int LINE_W       = 10,
  parameter int BLINK_FRAMES = 30
) (
  input logic clk,
  input logic rst_n,
  vga_mapa_grade_if.slave bus
);
  localparam int CW = $clog2(N_COLS);
  localparam int RW = $clog2(N_ROWS);
  localparam int XW = $clog2(CELL_W);
  localparam int YW = $clog2(CELL_H);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [10:0]   X_LO   = 11'(X0);
  localparam logic [10:0]   X_HI   = 11'(X0 + N_COLS*CELL_W + LINE_W);
  localparam logic [10:0]   Y_LO   = 11'(Y0);
  localparam logic [10:0]   Y_HI   = 11'(Y0 + N_ROWS*CELL_H + LINE_W);
  localparam logic [9:0]    X0_10  = 10'(X0);
  localparam logic [9:0]    Y0_10  = 10'(Y0);
  localparam logic [XW-1:0] X_LAST = XW'(CELL_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(CELL_H - 1);
  localparam logic [XW-1:0] X_LW   = XW'(LINE_W);
  localparam logic [YW-1:0] Y_LW   = YW'(LINE_W);
  localparam logic [4:0]    C_MAX  = 5'(N_COLS);
  localparam logic [4:0]    R_MAX  = 5'(N_ROWS);
  localparam logic [CW-1:0] C_LAST = CW'(N_COLS - 1);
  localparam logic [RW-1:0] R_LAST = RW'(N_ROWS - 1);
  localparam logic [CW:0]   C_NUM  = (CW+1)'(N_COLS);
  localparam logic [RW:0]   R_NUM  = (RW+1)'(N_ROWS);
  localparam logic [BW-1:0] B_LAST = BW'(BLINK_FRAMES - 1);

  logic [N_ROWS-1:0][N_COLS-1:0][1:0] cells_q, cells_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [1:0]    cst_q;
  logic          wr_ok;

  logic [XW-1:0] xm_q, xm_d;
  logic [YW-1:0] ym_q, ym_d;
  logic [4:0]    c_q, c_d;
  logic [4:0]    r_q, r_d;
  logic [9:0]    lin_q;
  logic          s1_q, s1_d;
  logic          xin, yin;

  logic          s2_q, g2_q, k2_q;
  logic          g2_d, k2_d, inb;
  logic [1:0]    st2_q, st2_d;
  logic [2:0]    rgb_q, rgb_d;

  logic          cmp_q, cmp_d, tick;
  logic [BW-1:0] bc_q, bc_d;
  logic          on_q, on_d;

  assign wr_ok = ({1'b0, bus.wr_col} < C_NUM) &&
                 ({1'b0, bus.wr_row} < R_NUM);

  // Cell store next state: clear wins over a single-cell write.
  always_comb begin
    cells_d = cells_q;
    if (bus.clr) begin
      cells_d = '0;
    end else if (bus.wr_en && wr_ok) begin
      cells_d[bus.wr_row][bus.wr_col] = bus.wr_state;
    end
  end

  // Cursor moves with wrap; opposing buttons cancel per axis.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (bus.btn_left && !bus.btn_right) begin
      col_d = (col_q == '0) ? C_LAST : col_q - CW'(1);
    end else if (bus.btn_right && !bus.btn_left) begin
      col_d = (col_q == C_LAST) ? '0 : col_q + CW'(1);
    end
    if (bus.btn_up && !bus.btn_down) begin
      row_d = (row_q == '0) ? R_LAST : row_q - RW'(1);
    end else if (bus.btn_down && !bus.btn_up) begin
      row_d = (row_q == R_LAST) ? '0 : row_q + RW'(1);
    end
  end

  // Cell store, cursor and the state under the cursor.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cells_q <= '0;
      col_q   <= '0;
      row_q   <= '0;
      cst_q   <= 2'b00;
    end else begin
      cells_q <= cells_d;
      col_q   <= col_d;
      row_q   <= row_d;
      cst_q   <= cells_q[row_q][col_q];
    end
  end

  // Position trackers: reload at the grid origin, step per pixel/line.
  always_comb begin
    xm_d = (xm_q == X_LAST) ? '0 : xm_q + XW'(1);
    c_d  = c_q;
    if (xm_q == X_LAST && c_q != C_MAX) c_d = c_q + 5'd1;
    if (bus.coluna == X0_10) begin
      xm_d = '0;
      c_d  = '0;
    end
    ym_d = ym_q;
    r_d  = r_q;
    if (bus.linha == Y0_10) begin
      ym_d = '0;
      r_d  = '0;
    end else if (bus.linha != lin_q) begin
      ym_d = (ym_q == Y_LAST) ? '0 : ym_q + YW'(1);
      if (ym_q == Y_LAST && r_q != R_MAX) r_d = r_q + 5'd1;
    end
    xin  = ({1'b0, bus.coluna} >= X_LO) && ({1'b0, bus.coluna} < X_HI);
    yin  = ({1'b0, bus.linha} >= Y_LO) && ({1'b0, bus.linha} < Y_HI);
    s1_d = bus.areaAtiva && xin && yin;
  end

  // Stage 1: tracker state for the sampled pixel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      xm_q  <= '0;
      ym_q  <= '0;
      c_q   <= '0;
      r_q   <= '0;
      lin_q <= '0;
      s1_q  <= 1'b0;
    end else begin
      xm_q  <= xm_d;
      ym_q  <= ym_d;
      c_q   <= c_d;
      r_q   <= r_d;
      lin_q <= bus.linha;
      s1_q  <= s1_d;
    end
  end

  // Gridline test, cell lookup and cursor match.
  always_comb begin
    inb   = (c_q < C_MAX) && (r_q < R_MAX);
    g2_d  = (xm_q < X_LW) || (ym_q < Y_LW);
    st2_d = 2'b00;
    k2_d  = 1'b0;
    if (inb) begin
      st2_d = cells_q[r_q[RW-1:0]][c_q[CW-1:0]];
      k2_d  = on_q && (c_q[CW-1:0] == col_q) &&
              (r_q[RW-1:0] == row_q);
    end
  end

  // Stage 2: classified pixel.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_q  <= 1'b0;
      g2_q  <= 1'b0;
      k2_q  <= 1'b0;
      st2_q <= 2'b00;
    end else begin
      s2_q  <= s1_q;
      g2_q  <= g2_d;
      k2_q  <= k2_d;
      st2_q <= st2_d;
    end
  end

  // Colour select: gridline, then cursor, then cell state.
  always_comb begin
    rgb_d = 3'b000;
    if (s2_q) begin
      if (g2_q) begin
        rgb_d = 3'b001;
      end else if (k2_q) begin
        rgb_d = 3'b110;
      end else begin
        unique case (st2_q)
          2'd0:    rgb_d = 3'b000;
          2'd1:    rgb_d = 3'b010;
          2'd2:    rgb_d = 3'b100;
          default: rgb_d = 3'b111;
        endcase
      end
    end
  end

  // Stage 3: registered colour.
  always_ff @(posedge clk) begin
    if (!rst_n) rgb_q <= 3'b000;
    else        rgb_q <= rgb_d;
  end

  assign cmp_d = (bus.linha == 10'd0) && (bus.coluna == 10'd0);
  assign tick  = cmp_d && !cmp_q;

  // Blink phase flips every BLINK_FRAMES frame ticks.
  always_comb begin
    bc_d = bc_q;
    on_d = on_q;
    if (tick) begin
      if (bc_q == B_LAST) begin
        bc_d = '0;
        on_d = ~on_q;
      end else begin
        bc_d = bc_q + BW'(1);
      end
    end
  end

  // Frame-tick edge detector and blink state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmp_q <= 1'b0;
      bc_q  <= '0;
      on_q  <= 1'b1;
    end else begin
      cmp_q <= cmp_d;
      bc_q  <= bc_d;
      on_q  <= on_d;
    end
  end

  assign bus.cursor_col   = col_q;
  assign bus.cursor_row   = row_q;
  assign bus.cursor_state = cst_q;
  assign bus.rgb_r        = rgb_q[2];
  assign bus.rgb_g        = rgb_q[1];
  assign bus.rgb_b        = rgb_q[0];
endmodule

// File: tb/tb_vga_mapa_grade.sv
// Directed bench for vga_mapa_grade: pixel vector table plus
// blink, cursor, write/clear and mid-frame reset sequences.
module tb_vga_mapa_grade;
  localparam int N_COLS = 8;
  localparam int N_ROWS = 8;

  typedef struct {
    int    op;
    int    wc;
    int    wr;
    int    ws;
    int    lin;
    int    col;
    bit    act;
    int    exp;
    string nm;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;
  vec_t tv[15];

  always #5 clk = ~clk;

  vga_mapa_grade_if #(.N_COLS(N_COLS), .N_ROWS(N_ROWS)) bus();

  vga_mapa_grade dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  function automatic vec_t mk(input int op, input int wc, input int wr,
                              input int ws, input int lin, input int col,
                              input bit act, input int exp,
                              input string nm);
    vec_t v;
    v.op = op; v.wc = wc; v.wr = wr; v.ws = ws;
    v.lin = lin; v.col = col; v.act = act; v.exp = exp; v.nm = nm;
    return v;
  endfunction

  function automatic int rgb();
    return int'({bus.rgb_r, bus.rgb_g, bus.rgb_b});
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Walk linha up through the grid top, then sweep coluna to the pixel.
  task automatic px(input int row, input int col, input bit act,
                    input int exp, input string nm);
    int l0;
    l0 = (row > 39) ? 39 : row;
    bus.areaAtiva = 1'b0;
    bus.coluna = 10'd0;
    for (int l = l0; l <= row; l++) begin
      bus.linha = 10'(l);
      step();
    end
    bus.areaAtiva = act;
    for (int c = 0; c <= col + 2; c++) begin
      bus.coluna = 10'(c);
      step();
    end
    chk(nm, rgb(), exp);
    bus.areaAtiva = 1'b0;
  endtask

  task automatic wr(input int c, input int r, input int s, input bit with_clr);
    bus.wr_en = 1'b1;
    bus.wr_col = 3'(c);
    bus.wr_row = 3'(r);
    bus.wr_state = 2'(s);
    bus.clr = with_clr;
    step();
    bus.wr_en = 1'b0;
    bus.clr = 1'b0;
  endtask

  task automatic clear();
    bus.clr = 1'b1;
    step();
    bus.clr = 1'b0;
  endtask

  task automatic btn(input bit u, input bit d, input bit l, input bit r);
    bus.btn_up = u;
    bus.btn_down = d;
    bus.btn_left = l;
    bus.btn_right = r;
    step();
    bus.btn_up = 1'b0;
    bus.btn_down = 1'b0;
    bus.btn_left = 1'b0;
    bus.btn_right = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      bus.linha = 10'd0;
      bus.coluna = 10'd0;
      step();
      bus.coluna = 10'd1;
      step();
    end
    bus.linha = 10'd1;
  endtask

  initial begin
    tv[0]  = mk(0, 0, 0, 0, 100,  25, 1'b1, 1, "grid_v");
    tv[1]  = mk(0, 0, 0, 0, 100, 700, 1'b1, 0, "outside_r");
    tv[2]  = mk(0, 0, 0, 0, 100,  25, 1'b0, 0, "inactive");
    tv[3]  = mk(1, 2, 1, 1, 115, 210, 1'b1, 2, "ship");
    tv[4]  = mk(1, 2, 1, 2, 115, 210, 1'b1, 4, "hit");
    tv[5]  = mk(1, 2, 1, 3, 115, 210, 1'b1, 7, "miss");
    tv[6]  = mk(2, 0, 0, 0, 115, 210, 1'b1, 0, "clr");
    tv[7]  = mk(0, 0, 0, 0,  70,  60, 1'b1, 6, "cursor");
    tv[8]  = mk(1, 1, 0, 1,  70, 135, 1'b1, 2, "ship_c1");
    tv[9]  = mk(0, 0, 0, 0, 445,  60, 1'b1, 1, "grid_bot");
    tv[10] = mk(0, 0, 0, 0, 450,  60, 1'b1, 0, "below");
    tv[11] = mk(0, 0, 0, 0,  70, 625, 1'b1, 1, "grid_right");
    tv[12] = mk(0, 0, 0, 0,  70, 630, 1'b1, 0, "right_out");
    tv[13] = mk(0, 0, 0, 0,  70,  19, 1'b1, 0, "left_out");
    tv[14] = mk(1, 7, 7, 2, 415, 585, 1'b1, 4, "last_cell");

    rst_n = 1'b0;
    bus.areaAtiva = 1'b0;
    bus.linha = 10'd1;
    bus.coluna = 10'd0;
    bus.btn_up = 1'b0;
    bus.btn_down = 1'b0;
    bus.btn_left = 1'b0;
    bus.btn_right = 1'b0;
    bus.wr_en = 1'b0;
    bus.wr_col = '0;
    bus.wr_row = '0;
    bus.wr_state = '0;
    bus.clr = 1'b0;
    repeat (3) step();
    chk("rst_rgb0", rgb(), 0);
    chk("rst_ccol", int'(bus.cursor_col), 0);
    chk("rst_crow", int'(bus.cursor_row), 0);
    chk("rst_cst", int'(bus.cursor_state), 0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 15; i++) begin
      if (tv[i].op == 1) wr(tv[i].wc, tv[i].wr, tv[i].ws, 1'b0);
      else if (tv[i].op == 2) clear();
      px(tv[i].lin, tv[i].col, tv[i].act, tv[i].exp, tv[i].nm);
    end

    ticks(29);
    px(70, 60, 1'b1, 6, "blink29");
    ticks(1);
    px(70, 60, 1'b1, 0, "blink30");
    ticks(30);
    px(70, 60, 1'b1, 6, "blink60");

    btn(1'b0, 1'b0, 1'b1, 1'b0);
    chk("left_wrap", int'(bus.cursor_col), 7);
    chk("left_row", int'(bus.cursor_row), 0);
    btn(1'b1, 1'b0, 1'b0, 1'b0);
    chk("up_wrap", int'(bus.cursor_row), 7);
    btn(1'b1, 1'b1, 1'b0, 1'b0);
    chk("updown", int'(bus.cursor_row), 7);
    btn(1'b0, 1'b1, 1'b0, 1'b1);
    chk("rd_col", int'(bus.cursor_col), 0);
    chk("rd_row", int'(bus.cursor_row), 0);
    repeat (3) btn(1'b0, 1'b1, 1'b0, 1'b1);
    chk("mv_col", int'(bus.cursor_col), 3);
    chk("mv_row", int'(bus.cursor_row), 3);
    step();
    chk("cs_water", int'(bus.cursor_state), 0);

    wr(3, 3, 1, 1'b0);
    chk("cs_lat0", int'(bus.cursor_state), 0);
    step();
    chk("cs_ship", int'(bus.cursor_state), 1);
    wr(3, 3, 1, 1'b1);
    step();
    chk("cs_clr", int'(bus.cursor_state), 0);

    wr(2, 1, 1, 1'b0);
    bus.linha = 10'd40;
    bus.areaAtiva = 1'b1;
    for (int c = 0; c <= 25; c++) begin
      bus.coluna = 10'(c);
      step();
    end
    chk("pre_rst", rgb(), 1);
    rst_n = 1'b0;
    bus.coluna = 10'd26;
    step();
    chk("rst_rgb", rgb(), 0);
    step();
    chk("rst_ccol2", int'(bus.cursor_col), 0);
    chk("rst_crow2", int'(bus.cursor_row), 0);
    rst_n = 1'b1;
    bus.coluna = 10'd20;
    step();
    chk("rel1", rgb(), 0);
    bus.coluna = 10'd21;
    step();
    chk("rel2", rgb(), 0);
    bus.coluna = 10'd22;
    step();
    chk("rel3", rgb(), 1);
    px(115, 210, 1'b1, 0, "rst_cell");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vga_mapa_grade.md
Name: vga_mapa_grade

Overview:
Parametrised Battleship board renderer for the VGA path. Draws an N_COLS x N_ROWS grid of gridlines and stores a 2-bit state per cell (water/ship/hit/miss), colouring each cell interior accordingly. Keeps a button-driven cursor that blinks at a frame-counted rate. Sits between the VGA timing generator (linha/coluna/areaAtiva) and the DAC rgb pins; the game FSM drives the cell write port.

Parameters:
N_COLS, 8, grid columns (2..16)
N_ROWS, 8, grid rows (2..16)
X0, 20, left pixel column of the grid
Y0, 40, top pixel row of the grid
CELL_W, 75, cell pitch in pixels, horizontal
CELL_H, 50, cell pitch in pixels, vertical
LINE_W, 10, gridline thickness in pixels (< CELL_W, < CELL_H)
BLINK_FRAMES, 30, frames per cursor blink phase

Ports:
clk  in  1  pixel clock
rst_n  in  1  synchronous reset, active low
areaAtiva  in  1  visible-area flag from timing generator
linha  in  10  current pixel row
coluna  in  10  current pixel column; advances by 1 per clk within a line
btn_up, btn_down, btn_left, btn_right  in  1 each  one-cycle move pulses
wr_en  in  1  cell write strobe
wr_col  in  $clog2(N_COLS)  write column
wr_row  in  $clog2(N_ROWS)  write row
wr_state  in  2  0 water, 1 ship, 2 hit, 3 miss
clr  in  1  one-cycle pulse: all cells to water
cursor_col  out  $clog2(N_COLS)  cursor column
cursor_row  out  $clog2(N_ROWS)  cursor row
cursor_state  out  2  state of cell under cursor
rgb_r, rgb_g, rgb_b  out  1 each  pixel colour

Behaviour:
- Reset (rst_n=0 at clk edge): all cells water, cursor (0,0), blink counter 0, blink phase on, rgb 000, cursor_state 0.
- Grid region: X0 <= coluna < X0+N_COLS*CELL_W+LINE_W and Y0 <= linha < Y0+N_ROWS*CELL_H+LINE_W. dx=coluna-X0, dy=linha-Y0.
- Gridline pixel: inside region and (dx mod CELL_W < LINE_W or dy mod CELL_H < LINE_W) -> blue 001.
- Otherwise inside region: cell c=dx/CELL_W, r=dy/CELL_H. Colour: water 000, ship 010, hit 100, miss 111. If (c,r)=cursor and blink phase on -> yellow 110, overriding the state colour.
- Outside region or areaAtiva=0 -> 000.
- Latency: rgb at edge t+2 reflects linha/coluna/areaAtiva sampled at edge t. Outputs registered. No division hardware: track dx mod CELL_W and c with counters reloaded when coluna==X0; track dy/r on linha change.
- Cell write: wr_en updates cell at edge; visible to the pixel pipeline from the next cycle. clr has priority over wr_en in the same cycle. Out-of-range wr_col/wr_row: write ignored.
- Cursor: each btn pulse moves one cell with wrap-around (left at col 0 -> N_COLS-1, down at N_ROWS-1 -> 0). up+down in the same cycle: no vertical move. left+right in the same cycle: no horizontal move. Vertical and horizontal moves in the same cycle both apply.
- cursor_state: registered, 1-cycle latency after a cursor move or cell write.
- Frame tick: first cycle where linha==0 and coluna==0 (rising edge of that compare). Blink counter counts ticks 0..BLINK_FRAMES-1; on wrap, toggles the phase and returns to 0.
- Reset mid-frame: pipeline is flushed; rgb is 000 until two valid cycles after release.

Test Plan:
- Reset, then drive coluna=25, linha=100, areaAtiva=1 -> rgb=001 two cycles later; coluna=700 -> 000; areaAtiva=0 at coluna=25 -> 000.
- Write (col 2, row 1)=ship; pixel coluna=20+150+40=210, linha=40+50+25=115 -> 010; write hit -> 100; write miss -> 111; clr -> 000.
- Cursor at (0,0), blink phase on, pixel (60,70) -> 110. After 30 frame ticks -> 000 (water). After 60 ticks -> 110 again.
- btn_left at reset -> cursor_col=7; btn_up -> cursor_row=7; btn_up and btn_down together -> row unchanged; btn_right and btn_down together -> (0,0).
- wr_en and clr in the same cycle for (3,3)=ship -> cell (3,3) reads water; cursor at (3,3) -> cursor_state=0 one cycle later.
- Pull rst_n low mid-line after writes -> cells water, cursor (0,0), rgb 000 for 2 cycles after release.
